// File: rtl/countdown_timer.sv
// countdown_timer: loads an M:SS.d BCD time and counts it down to 0:00.0
// in tenth-second steps; flags expiry with a level and a one-cycle pulse.
module countdown_timer #(
  parameter int unsigned TICKS_PER_TENTH = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic       start_resume,
  input  logic       stop,
  input  logic [3:0] load_min0,
  input  logic [3:0] load_sec1,
  input  logic [3:0] load_sec0,
  input  logic [3:0] load_milSec0,
  output logic [3:0] min0,
  output logic [3:0] sec1,
  output logic [3:0] sec0,
  output logic [3:0] milSec0,
  output logic       running,
  output logic       expired,
  output logic       done
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSE,
    EXPIRED
  } state_t;

  localparam logic [15:0] TC = 16'(TICKS_PER_TENTH - 1);

  state_t      state;
  logic [15:0] presc;

  logic [3:0] ld_min0;
  logic [3:0] ld_sec1;
  logic [3:0] ld_sec0;
  logic [3:0] ld_ms0;
  logic       ld_zero;

  logic [3:0] dc_min0;
  logic [3:0] dc_sec1;
  logic [3:0] dc_sec0;
  logic [3:0] dc_ms0;

  logic time_zero;
  logic last_tenth;
  logic tick;

  always_comb begin
    ld_min0 = (load_min0 > 4'd9) ? 4'd9 : load_min0;
    ld_sec1 = (load_sec1 > 4'd5) ? 4'd5 : load_sec1;
    ld_sec0 = (load_sec0 > 4'd9) ? 4'd9 : load_sec0;
    ld_ms0  = (load_milSec0 > 4'd9) ? 4'd9 : load_milSec0;
    ld_zero = ~|{ld_min0, ld_sec1, ld_sec0, ld_ms0};
  end

  // Borrow ripples upward only through digits that are already zero.
  always_comb begin
    dc_min0 = min0;
    dc_sec1 = sec1;
    dc_sec0 = sec0;
    dc_ms0  = milSec0;
    if (milSec0 != 4'd0) begin
      dc_ms0 = milSec0 - 4'd1;
    end else begin
      dc_ms0 = 4'd9;
      if (sec0 != 4'd0) begin
        dc_sec0 = sec0 - 4'd1;
      end else begin
        dc_sec0 = 4'd9;
        if (sec1 != 4'd0) begin
          dc_sec1 = sec1 - 4'd1;
        end else begin
          dc_sec1 = 4'd5;
          dc_min0 = min0 - 4'd1;
        end
      end
    end
  end

  always_comb begin
    time_zero  = ~|{min0, sec1, sec0, milSec0};
    last_tenth = ~|{min0, sec1, sec0} && (milSec0 == 4'd1);
    tick       = (presc == TC);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      presc   <= '0;
      min0    <= '0;
      sec1    <= '0;
      sec0    <= '0;
      milSec0 <= '0;
      running <= 1'b0;
      expired <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (load) begin
        min0    <= ld_min0;
        sec1    <= ld_sec1;
        sec0    <= ld_sec0;
        milSec0 <= ld_ms0;
        presc   <= '0;
        state   <= ld_zero ? IDLE : PAUSE;
        running <= 1'b0;
        expired <= 1'b0;
      end else if (state == RUN && stop) begin
        state   <= PAUSE;
        running <= 1'b0;
      end else if ((state == IDLE || state == PAUSE) &&
                   start_resume && !time_zero) begin
        state   <= RUN;
        running <= 1'b1;
      end else if (state == RUN) begin
        if (tick) begin
          presc   <= '0;
          min0    <= dc_min0;
          sec1    <= dc_sec1;
          sec0    <= dc_sec0;
          milSec0 <= dc_ms0;
          if (last_tenth) begin
            state   <= EXPIRED;
            running <= 1'b0;
            expired <= 1'b1;
            done    <= 1'b1;
          end
        end else begin
          presc <= presc + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_countdown_timer.sv
// tb_countdown_timer: directed and random stimulus against a model that
// keeps the time as an integer count of tenths.
module tb_countdown_timer;

  localparam int T = 10;
  localparam int M_IDLE = 0;
  localparam int M_RUN = 1;
  localparam int M_PAUSE = 2;
  localparam int M_EXP = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       load = 1'b0;
  logic       start_resume = 1'b0;
  logic       stop = 1'b0;
  logic [3:0] load_min0 = '0;
  logic [3:0] load_sec1 = '0;
  logic [3:0] load_sec0 = '0;
  logic [3:0] load_milSec0 = '0;
  logic [3:0] min0;
  logic [3:0] sec1;
  logic [3:0] sec0;
  logic [3:0] milSec0;
  logic       running;
  logic       expired;
  logic       done;

  int checks = 0;
  int errors = 0;

  int t_m = 0;
  int presc_m = 0;
  int mode_m = M_IDLE;
  bit done_m = 1'b0;

  countdown_timer #(.TICKS_PER_TENTH(T)) dut (
    .clk(clk),
    .reset(reset),
    .load(load),
    .start_resume(start_resume),
    .stop(stop),
    .load_min0(load_min0),
    .load_sec1(load_sec1),
    .load_sec0(load_sec0),
    .load_milSec0(load_milSec0),
    .min0(min0),
    .sec1(sec1),
    .sec0(sec0),
    .milSec0(milSec0),
    .running(running),
    .expired(expired),
    .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int t);
    return {4'(t / 600), 4'((t % 600) / 100), 4'((t % 100) / 10), 4'(t % 10)};
  endfunction

  function automatic int lim(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_reset();
    t_m = 0;
    presc_m = 0;
    mode_m = M_IDLE;
    done_m = 1'b0;
  endtask

  task automatic model_edge();
    done_m = 1'b0;
    if (!reset) begin
      model_reset();
    end else if (load) begin
      t_m = lim(int'(load_min0), 9) * 600 + lim(int'(load_sec1), 5) * 100 +
            lim(int'(load_sec0), 9) * 10 + lim(int'(load_milSec0), 9);
      presc_m = 0;
      mode_m = (t_m == 0) ? M_IDLE : M_PAUSE;
    end else if (stop && mode_m == M_RUN) begin
      mode_m = M_PAUSE;
    end else if (start_resume && t_m != 0 &&
                 (mode_m == M_IDLE || mode_m == M_PAUSE)) begin
      mode_m = M_RUN;
    end else if (mode_m == M_RUN) begin
      if (presc_m == T - 1) begin
        presc_m = 0;
        t_m--;
        if (t_m == 0) begin
          mode_m = M_EXP;
          done_m = 1'b1;
        end
      end else begin
        presc_m++;
      end
    end
  endtask

  task automatic compare();
    check("digits", 32'({min0, sec1, sec0, milSec0}), 32'(to_bcd(t_m)));
    check("flags", 32'({running, expired, done}),
          32'({mode_m == M_RUN, mode_m == M_EXP, done_m}));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic drive(input bit ld, input bit st, input bit sr,
                       input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] c, input logic [3:0] d);
    load = ld;
    stop = st;
    start_resume = sr;
    load_min0 = a;
    load_sec1 = b;
    load_sec0 = c;
    load_milSec0 = d;
  endtask

  task automatic load_val(input logic [3:0] a, input logic [3:0] b,
                          input logic [3:0] c, input logic [3:0] d);
    drive(1, 0, 0, a, b, c, d);
    step();
    drive(0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    // Reset held with random inputs
    for (int i = 0; i < 6; i++) begin
      drive(1'($urandom), 1'($urandom), 1'($urandom), 4'($urandom),
            4'($urandom), 4'($urandom), 4'($urandom));
      step();
    end
    check("rst_digits", 32'({min0, sec1, sec0, milSec0}), 32'h0);
    check("rst_flags", 32'({running, expired, done}), 32'h0);
    #3 reset = 1'b1;
    drive(0, 0, 1, 0, 0, 0, 0);
    steps(3);
    check("idle_zero_start", 32'(running), 32'h0);

    // Basic countdown of 0:00.3
    load_val(0, 0, 0, 3);
    drive(0, 0, 1, 0, 0, 0, 0);
    step();
    for (int i = 1; i <= 32; i++) begin
      step();
      if (i == 10) check("basic_10", 32'(milSec0), 32'd2);
      if (i == 20) check("basic_20", 32'(milSec0), 32'd1);
      if (i == 30) check("basic_done", 32'({expired, done}), 32'h3);
      if (i == 31) check("basic_done_low", 32'({expired, done}), 32'h2);
    end

    // Borrow chain from 1:00.0
    drive(0, 0, 0, 0, 0, 0, 0);
    load_val(1, 0, 0, 0);
    drive(0, 0, 1, 0, 0, 0, 0);
    step();
    steps(T);
    check("borrow_0599", 32'({min0, sec1, sec0, milSec0}), 32'h0599);
    steps(599 * T);
    check("borrow_zero", 32'({min0, sec1, sec0, milSec0, expired}), 32'h1);

    // Pause at prescaler 4, resume
    load_val(0, 0, 1, 0);
    drive(0, 0, 1, 0, 0, 0, 0);
    step();
    steps(4);
    drive(0, 1, 0, 0, 0, 0, 0);
    steps(50);
    drive(0, 0, 1, 0, 0, 0, 0);
    step();
    steps(5);
    check("resume_5", 32'({sec0, milSec0}), 32'h10);
    step();
    check("resume_6", 32'({sec0, milSec0}), 32'h09);
    drive(0, 1, 1, 0, 0, 0, 0);
    step();
    check("stop_start_pause", 32'(running), 32'h0);

    // Stop on the terminal tick, then resume
    load_val(0, 0, 0, 2);
    drive(0, 0, 1, 0, 0, 0, 0);
    step();
    steps(T - 1);
    drive(0, 1, 0, 0, 0, 0, 0);
    step();
    drive(0, 0, 1, 0, 0, 0, 0);
    steps(2);
    check("stop_tc_resume", 32'(milSec0), 32'd1);

    // Clamping and load priority
    drive(1, 0, 0, 12, 7, 15, 10);
    step();
    check("clamp", 32'({min0, sec1, sec0, milSec0}), 32'h9599);
    drive(1, 1, 1, 0, 2, 3, 4);
    step();
    check("load_prio", 32'({running, expired}), 32'h0);

    // Load beats the zero-reaching tick
    load_val(0, 0, 0, 1);
    drive(0, 0, 1, 0, 0, 0, 0);
    step();
    steps(T - 1);
    drive(1, 0, 0, 0, 0, 0, 5);
    step();
    check("load_vs_zero", 32'({expired, done, milSec0}), 32'h5);
    drive(0, 0, 0, 0, 0, 0, 0);

    // Reset while done is in flight
    load_val(0, 0, 0, 1);
    drive(0, 0, 1, 0, 0, 0, 0);
    step();
    steps(T);
    #3 reset = 1'b0;
    model_reset();
    #1;
    check("async_rst", 32'({min0, sec1, sec0, milSec0, running, expired, done}),
          32'h0);
    steps(2);
    #3 reset = 1'b1;
    steps(T + 3);

    // Reset mid-run
    load_val(0, 0, 5, 0);
    drive(0, 0, 1, 0, 0, 0, 0);
    step();
    steps(17);
    #2 reset = 1'b0;
    model_reset();
    #1;
    compare();
    step();
    #3 reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    steps(4);

    // Random phase
    for (int i = 0; i < 4000; i++) begin
      drive($urandom_range(0, 149) == 0, $urandom_range(0, 39) == 0,
            $urandom_range(0, 3) == 0,
            ($urandom_range(0, 19) == 0) ? 4'($urandom_range(0, 15)) : 4'd0,
            ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15)) : 4'd0,
            4'($urandom_range(0, 2)), 4'($urandom_range(0, 15)));
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
